// File: rtl/ysyx_24100029_icache.sv
// rtl/ysyx_24100029_icache.sv - direct-mapped read-only I-cache with AXI4 refill
// ICACHE_EN enables the cache; when undefined every fetch bypasses to memory.
module ysyx_24100029_icache #(
  parameter int SETS        = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fence_i,
  input  logic        s_arvalid,
  output logic        s_arready,
  input  logic [31:0] s_araddr,
  input  logic [3:0]  s_arid,
  input  logic [7:0]  s_arlen,
  input  logic [2:0]  s_arsize,
  input  logic [1:0]  s_arburst,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rlast,
  output logic [3:0]  s_rid,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic [3:0]  m_rid
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_MISS_AR, S_MISS_R, S_RESP
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_addr;
  logic [3:0]  r_id;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_beat;
  logic        w_unused;

  assign w_beat = (r_state == S_MISS_R) && m_rvalid;

`ifdef ICACHE_EN
  localparam int OFS = $clog2(BLOCK_WORDS);
  localparam int IDX = $clog2(SETS);
  localparam int TAG = 30 - OFS - IDX;

  logic [SETS-1:0] r_valid;
  logic [TAG-1:0]  r_tag  [SETS];
  logic [31:0]     r_data [SETS][BLOCK_WORDS];
  logic [OFS-1:0]  r_cnt;
  logic [1:0]      r_err;
  logic            r_fenced;

  logic [IDX-1:0]  w_idx;
  logic [OFS-1:0]  w_ofs;
  logic [TAG-1:0]  w_tag;
  logic            w_hit;
  logic            w_last;
  logic [1:0]      w_err_next;

  assign w_idx      = r_addr[OFS+2 +: IDX];
  assign w_ofs      = r_addr[2 +: OFS];
  assign w_tag      = r_addr[31 -: TAG];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last     = m_rlast || (r_cnt == OFS'(BLOCK_WORDS - 1));
  assign w_err_next = r_err | m_rresp;

  // r_fenced remembers a flush that landed while this line was being filled
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt    <= '0;
      r_err    <= '0;
      r_fenced <= 1'b0;
      r_valid  <= '0;
    end else begin
      if (r_state == S_MISS_AR) begin
        r_cnt <= '0;
        r_err <= '0;
      end else if (w_beat) begin
        r_cnt <= r_cnt + 1'b1;
        r_err <= w_err_next;
      end
      if (r_state == S_LOOKUP)
        r_fenced <= 1'b0;
      else if (fence_i)
        r_fenced <= 1'b1;
      if (fence_i)
        r_valid <= '0;
      else if (w_beat && w_last && (w_err_next == 2'b00) && !r_fenced)
        r_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_beat) begin
      r_data[w_idx][r_cnt] <= m_rdata;
      if (w_last)
        r_tag[w_idx] <= w_tag;
    end
  end

  assign m_araddr = {r_addr[31:OFS+2], {(OFS+2){1'b0}}};
  assign m_arlen  = 8'(BLOCK_WORDS - 1);
  assign w_unused = ^{s_arlen, s_arsize, s_arburst, m_rid, r_addr[1:0]};
`else
  assign m_araddr = {r_addr[31:2], 2'b00};
  assign m_arlen  = 8'd0;
  assign w_unused = ^{s_arlen, s_arsize, s_arburst, m_rid, r_addr[1:0],
                      fence_i, m_rlast, 1'(SETS), 1'(BLOCK_WORDS)};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_rdata <= '0;
      r_rresp <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && s_arvalid) begin
        r_addr <= s_araddr;
        r_id   <= s_arid;
      end
`ifdef ICACHE_EN
      if (r_state == S_LOOKUP && w_hit) begin
        r_rdata <= r_data[w_idx][w_ofs];
        r_rresp <= 2'b00;
      end
      if (w_beat && (r_cnt == w_ofs))
        r_rdata <= m_rdata;
      if (w_beat && w_last)
        r_rresp <= w_err_next;
`else
      if (w_beat) begin
        r_rdata <= m_rdata;
        r_rresp <= m_rresp;
      end
`endif
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef ICACHE_EN
      S_IDLE:    if (s_arvalid) w_next = S_LOOKUP;
      S_LOOKUP:  w_next = w_hit ? S_RESP : S_MISS_AR;
      S_MISS_R:  if (m_rvalid && w_last) w_next = S_RESP;
`else
      S_IDLE:    if (s_arvalid) w_next = S_MISS_AR;
      S_MISS_R:  if (m_rvalid) w_next = S_RESP;
`endif
      S_MISS_AR: if (m_arready) w_next = S_MISS_R;
      S_RESP:    if (s_rready) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // arready is gated by reset so it reads 0 for the whole reset window
  assign s_arready = reset && (r_state == S_IDLE);
  assign s_rvalid  = (r_state == S_RESP);
  assign s_rlast   = s_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = r_rresp;
  assign s_rid     = r_id;
  assign m_arvalid = (r_state == S_MISS_AR);
  assign m_arid    = 4'd0;
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_rready  = (r_state == S_MISS_R);

endmodule

// File: tb/tb_ysyx_24100029_icache.sv
// tb/tb_ysyx_24100029_icache.sv - bench for ysyx_24100029_icache
// Expectations follow ICACHE_EN: cached behaviour when defined, bypass otherwise.
module tb_ysyx_24100029_icache;

  logic        clock = 1'b0;
  logic        reset;
  logic        fence_i;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [3:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst;
  logic        s_rvalid, s_rready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic [3:0]  s_rid;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [3:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  logic [3:0]  m_rid;

  ysyx_24100029_icache dut (
    .clock(clock), .reset(reset), .fence_i(fence_i),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rlast(s_rlast), .s_rid(s_rid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rid(m_rid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] addr;
    int          err_beat;
    int          fence_k;
    int          ar_stall;
    int          r_stall;
    int          abort_k;
    bit          pre_fence;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_refills;
    int          exp_lat;
  } vec_t;

`ifdef ICACHE_EN
  localparam logic [31:0] AR_MASK   = 32'hFFFF_FFF0;
  localparam logic [7:0]  EXP_ARLEN = 8'd3;
`else
  localparam logic [31:0] AR_MASK   = 32'hFFFF_FFFC;
  localparam logic [7:0]  EXP_ARLEN = 8'd0;
`endif

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_vec  = -1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h3000_0000) >> 2);
  endfunction

  function automatic void add(input logic [31:0] addr, input int err_beat, input int fence_k,
                              input int ar_stall, input int r_stall, input int abort_k,
                              input bit pre_fence, input logic [31:0] exp_data,
                              input logic [1:0] exp_resp, input int exp_refills, input int exp_lat);
    vec_t v;
    v.addr = addr; v.err_beat = err_beat; v.fence_k = fence_k; v.ar_stall = ar_stall;
    v.r_stall = r_stall; v.abort_k = abort_k; v.pre_fence = pre_fence; v.exp_data = exp_data;
    v.exp_resp = exp_resp; v.exp_refills = exp_refills; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %h, expected %h", cur_vec, name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int vi);
    int k = 0, refills = 0, bidx = 0, blen = 0, stall = v.ar_stall, lat = -1;
    bit burst = 0, ar_seen = 0;
    logic [31:0] baddr = '0, ar_first = '0;
    cur_vec = vi;
    if (v.pre_fence) begin
      fence_i = 1'b1;
      @(negedge clock);
      fence_i = 1'b0;
    end
    check("arready_idle", 32'(s_arready), 32'd1);
    s_arvalid = 1'b1;
    s_araddr  = v.addr;
    s_arid    = 4'(vi);
    while (lat < 0 && k < 100) begin
      @(negedge clock);
      k++;
      s_arvalid = 1'b0;
      fence_i   = 1'b0;
      if (k == v.abort_k) begin
        reset = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; m_rdata = '0;
        #1;
        check("rst_outputs", {27'b0, s_arready, s_rvalid, m_arvalid, m_rready, s_rlast}, 32'd0);
        check("rst_rdata", s_rdata, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rst_arready", 32'(s_arready), 32'd1);
        return;
      end
      if (k == v.fence_k) fence_i = 1'b1;
      if (s_rvalid) begin
        lat = k;
        m_rvalid  = 1'b0;
        m_arready = 1'b0;
      end else begin
        if (burst) begin
          m_rvalid = 1'b1;
          m_rdata  = mem_word(baddr + 32'(bidx * 4));
          m_rresp  = (bidx == v.err_beat) ? 2'b10 : 2'b00;
          m_rlast  = (bidx == blen - 1);
          if (m_rready) begin
            bidx++;
            if (bidx == blen) burst = 0;
          end
        end else begin
          m_rvalid = 1'b0;
          m_rlast  = 1'b0;
          m_rresp  = 2'b00;
        end
        if (m_arvalid) begin
          if (!ar_seen) begin
            ar_seen  = 1;
            ar_first = m_araddr;
            check("m_araddr", m_araddr, v.addr & AR_MASK);
            check("ar_attrs", {15'b0, m_arid, m_arlen, m_arsize, m_arburst},
                  {15'b0, 4'd0, EXP_ARLEN, 3'b010, 2'b01});
          end else begin
            check("ar_stable", m_araddr, ar_first);
          end
          if (stall > 0) begin
            m_arready = 1'b0;
            stall--;
          end else begin
            m_arready = 1'b1;
            refills++;
            baddr = m_araddr;
            blen  = int'(m_arlen) + 1;
            bidx  = 0;
            burst = 1;
          end
        end else begin
          m_arready = 1'b0;
        end
      end
    end
    m_rvalid = 1'b0; m_arready = 1'b0; m_rlast = 1'b0; fence_i = 1'b0;
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL vec%0d timeout: no s_rvalid within %0d cycles", vi, k);
      return;
    end
    check("latency", lat, v.exp_lat);
    check("refills", refills, v.exp_refills);
    check("s_rdata", s_rdata, v.exp_data);
    check("s_rresp", 32'(s_rresp), 32'(v.exp_resp));
    check("s_rid_rlast", {27'b0, s_rid, s_rlast}, {27'b0, 4'(vi), 1'b1});
    for (int i = 0; i < v.r_stall; i++) begin
      @(negedge clock);
      check("rdata_hold", s_rdata, v.exp_data);
      check("rvalid_hold", 32'(s_rvalid), 32'd1);
    end
    s_rready = 1'b1;
    @(negedge clock);
    s_rready = 1'b0;
    check("rvalid_drop", 32'(s_rvalid), 32'd0);
    check("arready_after", 32'(s_arready), 32'd1);
  endtask

  initial begin
    //  addr          err fk st rs ab pf data       resp refills lat
`ifdef ICACHE_EN
    add(32'h3000_0004, -1, 0, 0, 0, 0, 0, 32'hA1, 2'b00, 1, 7);
    add(32'h3000_000C, -1, 0, 0, 0, 0, 0, 32'hA3, 2'b00, 0, 2);
    add(32'h3000_0100, -1, 0, 0, 0, 0, 0, 32'hE0, 2'b00, 1, 7);
    add(32'h3000_0000, -1, 0, 0, 0, 0, 0, 32'hA0, 2'b00, 1, 7);
    add(32'h3000_0108, -1, 0, 0, 0, 0, 0, 32'hE2, 2'b00, 1, 7);
    add(32'h3000_0024,  2, 0, 0, 0, 0, 0, 32'hA9, 2'b10, 1, 7);
    add(32'h3000_0028, -1, 0, 0, 0, 0, 0, 32'hAA, 2'b00, 1, 7);
    add(32'h3000_002C, -1, 0, 0, 0, 0, 0, 32'hAB, 2'b00, 0, 2);
    add(32'h3000_0044, -1, 4, 0, 0, 0, 0, 32'hB1, 2'b00, 1, 7);
    add(32'h3000_0040, -1, 0, 0, 0, 0, 0, 32'hB0, 2'b00, 1, 7);
    add(32'h3000_0048, -1, 0, 0, 0, 0, 0, 32'hB2, 2'b00, 0, 2);
    add(32'h3000_0048, -1, 0, 0, 0, 0, 1, 32'hB2, 2'b00, 1, 7);
    add(32'h3000_0084, -1, 0, 5, 0, 0, 0, 32'hC1, 2'b00, 1, 12);
    add(32'h3000_0088, -1, 0, 0, 3, 0, 0, 32'hC2, 2'b00, 0, 2);
    add(32'h3000_008C, -1, 1, 0, 0, 0, 0, 32'hC3, 2'b00, 0, 2);
    add(32'h3000_0080, -1, 0, 0, 0, 0, 0, 32'hC0, 2'b00, 1, 7);
    add(32'h3000_0004, -1, 0, 0, 0, 0, 0, 32'hA1, 2'b00, 1, 7);
    add(32'h3000_00C4, -1, 0, 0, 0, 4, 0, 32'h00, 2'b00, 0, 0);
    add(32'h3000_0004, -1, 0, 0, 0, 0, 0, 32'hA1, 2'b00, 1, 7);
`else
    add(32'h3000_0004, -1, 0, 0, 0, 0, 0, 32'hA1, 2'b00, 1, 3);
    add(32'h3000_000C, -1, 0, 0, 0, 0, 0, 32'hA3, 2'b00, 1, 3);
    add(32'h3000_0007, -1, 0, 0, 0, 0, 0, 32'hA1, 2'b00, 1, 3);
    add(32'h3000_0024,  0, 0, 0, 0, 0, 0, 32'hA9, 2'b10, 1, 3);
    add(32'h3000_0024, -1, 0, 0, 0, 0, 0, 32'hA9, 2'b00, 1, 3);
    add(32'h3000_0010, -1, 1, 0, 0, 0, 0, 32'hA4, 2'b00, 1, 3);
    add(32'h3000_0010, -1, 0, 0, 0, 0, 1, 32'hA4, 2'b00, 1, 3);
    add(32'h3000_0084, -1, 0, 5, 0, 0, 0, 32'hC1, 2'b00, 1, 8);
    add(32'h3000_0088, -1, 0, 0, 3, 0, 0, 32'hC2, 2'b00, 1, 3);
    add(32'h3000_00C4, -1, 0, 0, 0, 2, 0, 32'h00, 2'b00, 0, 0);
    add(32'h3000_0004, -1, 0, 0, 0, 0, 0, 32'hA1, 2'b00, 1, 3);
`endif
    reset = 1'b0; fence_i = 1'b0;
    s_arvalid = 1'b0; s_araddr = '0; s_arid = '0;
    s_arlen = 8'd0; s_arsize = 3'b010; s_arburst = 2'b01; s_rready = 1'b0;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = 2'b00; m_rlast = 1'b0; m_rid = '0;
    #1;
    check("reset_outputs", {27'b0, s_arready, s_rvalid, m_arvalid, m_rready, s_rlast}, 32'd0);
    check("reset_rdata", s_rdata, 32'd0);
    repeat (3) @(negedge clock);
    check("reset_arready_low", 32'(s_arready), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    check("reset_arready_idle", 32'(s_arready), 32'd1);
    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
